// File: rtl/sma_in.sv
// sma_in -- Avalon-MM input port with rising-edge capture and a level interrupt.
//
// Each in_port bit passes through a two-flop synchronizer. The synchronized
// value, optionally debounced, is the qualified input q. A registered rising
// edge on any bit of q sets a sticky edge_capture bit. Software clears that bit
// by writing 1 to it. irq is the registered OR of (edge_capture & irq_mask).
//
// Bus protocol: there is no valid/ready handshake. A write happens on the
// clock edge where chipselect=1 and write_n=0. A read never stalls: readdata
// is a purely combinational function of address and ignores chipselect.
//
// Register map (word address):
//   0 data         (q, read-only)
//   1 reserved     (reads 0, writes ignored)
//   2 irq_mask     (R/W)
//   3 edge_capture (read, write-1-to-clear; a new edge wins over a clear)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   address     word address [1:0]
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data [31:0]
//   in_port     asynchronous external inputs [WIDTH-1:0]
//   readdata    read data [31:0], zero above WIDTH
//   irq         level interrupt, active-high
//
// Optional feature: define SMA_IN_DEBOUNCE_EN to add a per-bit debounce
// filter. q then follows a synchronized bit only after that bit has differed
// from q for DEBOUNCE_CYCLES consecutive clocks.

module sma_in #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_prev_q;
  logic [WIDTH-1:0] edge_det_q;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;
  logic             wr;
  logic [WIDTH-1:0] clr_bits;

  // Only writedata[WIDTH-1:0] carries register content.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Two-flop synchronizer on every input bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef SMA_IN_DEBOUNCE_EN
  // Per-bit debounce filter. The counter runs while the synchronized bit
  // differs from q. It resets when the bit returns to q. It also resets when q
  // flips after DEBOUNCE_CYCLES consecutive differing clocks.
  logic [15:0]      db_cnt_q [WIDTH];
  logic [WIDTH-1:0] db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign q = db_q;
`else
  logic [15:0] unused_db_cfg;
  assign unused_db_cfg = 16'(DEBOUNCE_CYCLES);
  assign q = sync2_q;
`endif

  assign wr       = chipselect & ~write_n;
  assign clr_bits = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
    // OR in the detected edge after applying the clear, so a new edge wins.
    edge_cap_d = (edge_cap_q & ~clr_bits) | edge_det_q;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // q_prev resets to 0, so a bit that is already high at reset release
  // produces exactly one normal rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_prev_q   <= '0;
      edge_det_q <= '0;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      q_prev_q   <= q;
      edge_det_q <= q & ~q_prev_q;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = q;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_cap_q;
      default: readdata = '0;
    endcase
  end

endmodule
